// File: rtl/key_conditioner.sv
// Purpose: synchronize, debounce and edge-detect active-low push-buttons; optional one-shot long-press pulse (define KEY_COND_HOLD_EN).
// Latency: level/press/release register DEBOUNCE_CYCLES+1 edges after the first edge that samples a stable raw level.
// Backpressure: none; every output is a free-running registered level or single-cycle pulse.
module key_conditioner #(
    parameter int N_KEYS          = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 50000000
) (
    input  logic              MAX10_CLK1_50,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_hold
);

    localparam int            DW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } key_state_e;

    if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_param_check
        $error("key_conditioner: DEBOUNCE_CYCLES and HOLD_CYCLES must be >= 1");
    end

    logic [N_KEYS-1:0] sync1_q;
    logic [N_KEYS-1:0] sync2_q;

    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= ~key_raw;
            sync2_q <= sync1_q;
        end
    end

    for (genvar g = 0; g < N_KEYS; g++) begin : g_key
        key_state_e    state_q;
        logic [DW-1:0] db_cnt_q;
        logic [DW-1:0] cnt_inc;
        logic          accept;
        logic          level_q;
        logic          press_q;
        logic          release_q;

        // Leaving a stable state starts the run at 1, so DEBOUNCE_CYCLES=1 accepts at once.
        assign cnt_inc = (state_q == PRESS_WAIT || state_q == RELEASE_WAIT)
                       ? ((db_cnt_q == DB_LAST) ? DB_LAST : db_cnt_q + DW'(1))
                       : DW'(1);
        assign accept  = (cnt_inc == DB_LAST);

        always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
            if (!rst_n) begin
                state_q   <= RELEASED;
                db_cnt_q  <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                case (state_q)
                    RELEASED, PRESS_WAIT: begin
                        if (!sync2_q[g]) begin
                            db_cnt_q <= '0;
                            state_q  <= RELEASED;
                        end else if (accept) begin
                            db_cnt_q <= '0;
                            level_q  <= 1'b1;
                            press_q  <= 1'b1;
                            state_q  <= PRESSED;
                        end else begin
                            db_cnt_q <= cnt_inc;
                            state_q  <= PRESS_WAIT;
                        end
                    end
                    PRESSED, RELEASE_WAIT: begin
                        if (sync2_q[g]) begin
                            db_cnt_q <= '0;
                            state_q  <= PRESSED;
                        end else if (accept) begin
                            db_cnt_q  <= '0;
                            level_q   <= 1'b0;
                            release_q <= 1'b1;
                            state_q   <= RELEASED;
                        end else begin
                            db_cnt_q <= cnt_inc;
                            state_q  <= RELEASE_WAIT;
                        end
                    end
                    default: begin
                        db_cnt_q <= '0;
                        state_q  <= RELEASED;
                    end
                endcase
            end
        end

        assign key_level[g]   = level_q;
        assign key_press[g]   = press_q;
        assign key_release[g] = release_q;

`ifdef KEY_COND_HOLD_EN
        localparam int            HW        = $clog2(HOLD_CYCLES + 1);
        localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES);

        logic [HW-1:0] hold_cnt_q;
        logic          hold_q;

        // Counting spans PRESSED and RELEASE_WAIT so a release bounce does not restart it.
        always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
            if (!rst_n) begin
                hold_cnt_q <= '0;
                hold_q     <= 1'b0;
            end else begin
                hold_q <= 1'b0;
                if (!level_q) begin
                    hold_cnt_q <= '0;
                end else if (hold_cnt_q != HOLD_LAST) begin
                    hold_cnt_q <= hold_cnt_q + HW'(1);
                    if (hold_cnt_q + HW'(1) == HOLD_LAST) begin
                        hold_q <= 1'b1;
                    end
                end
            end
        end

        assign key_hold[g] = hold_q;
`endif
    end

`ifndef KEY_COND_HOLD_EN
    assign key_hold = '0;
`endif

endmodule
